// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and write-path state encoding.
package axil_pkg;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GOT_AW = 2'd1,
      GOT_W  = 2'd2,
      RESP   = 2'd3
   } axil_wr_state_t;

endpackage

// File: rtl/axil_wr_capture.sv
// AW/W capture registers and address range check for the AXI4-Lite write slave.
// Range checking is compiled in only when AXIL_WR_RANGE_CHECK_EN is defined.
module axil_wr_capture
   import axil_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                aw_hs_i,
   input  logic                w_hs_i,
   input  logic [ADDR_W-1:0]   awaddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic [IDX_W-1:0]    idx_o,
   output logic [DATA_W-1:0]   data_o,
   output logic [DATA_W/8-1:0] strb_o,
   output logic                err_o,
   output logic                wr_ok_o
);

   logic [IDX_W-1:0]    idx_q,  idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W/8-1:0] strb_q, strb_d;
   logic                err_q,  err_d;
   logic                err_now;

`ifdef AXIL_WR_RANGE_CHECK_EN
   function automatic logic range_err(input logic [ADDR_W-1:0] addr);
      return (addr[1:0] != 2'b00) ||
             ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(NUM_REGS));
   endfunction

   assign err_now = range_err(awaddr_i);
`else
   logic unused_addr;
   assign unused_addr = ^{awaddr_i[ADDR_W-1:IDX_W+2], awaddr_i[1:0]};
   assign err_now     = 1'b0;
`endif

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      strb_d = strb_q;
      err_d  = err_q;
      if (aw_hs_i) begin
         idx_d = awaddr_i[IDX_W+1:2];
         err_d = err_now;
      end
      if (w_hs_i) begin
         data_d = wdata_i;
         strb_d = wstrb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q  <= '0;
         data_q <= '0;
         strb_q <= '0;
         err_q  <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
         strb_q <= strb_d;
         err_q  <= err_d;
      end
   end

   // Look-ahead view including this cycle's handshake, so the FSM can decide
   // the response and write pulse on the same edge that completes the pair.
   assign err_o   = err_d;
   assign wr_ok_o = !err_d && (strb_d != '0);

   assign idx_o  = idx_q;
   assign data_o = data_q;
   assign strb_o = strb_q;

endmodule

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write responder: AW/W in either order, one registered bank write
// strobe, B response. Optional range check via AXIL_WR_RANGE_CHECK_EN.
module axi_lite_write_slave
   import axil_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic [2:0]          AWPROT,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   output logic                o_wr_en,
   output logic [IDX_W-1:0]    o_wr_idx,
   output logic [DATA_W-1:0]   o_wr_data,
   output logic [DATA_W/8-1:0] o_wr_strb
);

   axil_wr_state_t state_q, state_d;
   logic           wr_en_q, wr_en_d;
   logic [1:0]     bresp_q, bresp_d;
   logic           aw_hs, w_hs, enter_resp;
   logic           cap_err, cap_wr_ok;
   logic           unused_awprot;

   assign unused_awprot = ^AWPROT;

   // Ready depends on state only, never on VALID.
   assign AWREADY = (state_q == IDLE) || (state_q == GOT_W);
   assign WREADY  = (state_q == IDLE) || (state_q == GOT_AW);
   assign aw_hs   = AWVALID && AWREADY;
   assign w_hs    = WVALID && WREADY;

   axil_wr_capture #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_capture (
      .clk_i    (ACLK),
      .rst_i    (ARESET),
      .aw_hs_i  (aw_hs),
      .w_hs_i   (w_hs),
      .awaddr_i (AWADDR),
      .wdata_i  (WDATA),
      .wstrb_i  (WSTRB),
      .idx_o    (o_wr_idx),
      .data_o   (o_wr_data),
      .strb_o   (o_wr_strb),
      .err_o    (cap_err),
      .wr_ok_o  (cap_wr_ok)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (aw_hs && w_hs) state_d = RESP;
            else if (aw_hs)    state_d = GOT_AW;
            else if (w_hs)     state_d = GOT_W;
         end
         GOT_AW:  if (w_hs)   state_d = RESP;
         GOT_W:   if (aw_hs)  state_d = RESP;
         RESP:    if (BREADY) state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   always_comb begin
      enter_resp = (state_d == RESP) && (state_q != RESP);
      wr_en_d    = enter_resp && cap_wr_ok;
      bresp_d    = bresp_q;
      if (enter_resp) bresp_d = cap_err ? AXI_SLVERR : AXI_OKAY;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
         wr_en_q <= 1'b0;
         bresp_q <= AXI_OKAY;
      end else begin
         state_q <= state_d;
         wr_en_q <= wr_en_d;
         bresp_q <= bresp_d;
      end
   end

   assign BVALID  = (state_q == RESP);
   assign BRESP   = bresp_q;
   assign o_wr_en = wr_en_q;

endmodule
